// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract unit, one bit slice per clock, LSB first.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   request, accepted only while ready=1
//   mode    0 = a+b, 1 = a-b (sampled with start)
//   a, b    WIDTH-bit operands (sampled with start)
//   ready   high while idle
//   done    one-cycle pulse coinciding with the update of result/cout
//   result  sum or difference modulo 2^WIDTH, held until the next completion
//   cout    carry-out (add) or borrow-out (sub) of the MSB
//   ovf     signed overflow, present only when SERIAL_ADDSUB_OVF_EN is defined
//
// Timing: start accepted at edge t, WIDTH RUN cycles, then one DONE cycle during
// which done=1 and ready=0; the next request can be accepted WIDTH+2 edges later.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-2:0] res_sr_r;     // bits already produced; the MSB comes from the last slice
  logic [CW-1:0]    cnt_r;
  logic             mode_r;
  logic             c_r;
  logic             ready_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             cout_r;

  logic             x_s;
  logic             y_s;
  logic             sum_s;
  logic             c_nxt_s;
  logic             last_s;
  logic [WIDTH-1:0] res_shift_s;

`ifdef SERIAL_ADDSUB_OVF_EN
  logic             a_msb_r;
  logic             b_msb_r;
  logic             ovf_r;
  logic             ovf_s;
`endif

  assign last_s      = (cnt_r == CW'(WIDTH - 1));
  assign res_shift_s = {sum_s, res_sr_r};

  // Full-adder / full-subtractor bit slice on the current operand LSBs.
  always_comb begin
    x_s   = a_sr_r[0];
    y_s   = b_sr_r[0];
    sum_s = x_s ^ y_s ^ c_r;
    if (mode_r) begin
      c_nxt_s = (~x_s & y_s) | (~(x_s ^ y_s) & c_r);
    end else begin
      c_nxt_s = (x_s & y_s) | (c_r & (x_s ^ y_s));
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  // Signed overflow from the latched operand MSBs and the final result bit.
  always_comb begin
    if (mode_r) begin
      ovf_s = (a_msb_r != b_msb_r) & (sum_s != a_msb_r);
    end else begin
      ovf_s = (a_msb_r == b_msb_r) & (sum_s != a_msb_r);
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand/result shift registers, carry flop, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      res_sr_r <= '0;
      cnt_r    <= '0;
      mode_r   <= 1'b0;
      c_r      <= 1'b0;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      result_r <= '0;
      cout_r   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      ovf_r    <= 1'b0;
`endif
    end else begin
      ready_r <= (state_nxt_s == IDLE);
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sr_r   <= a;
            b_sr_r   <= b;
            mode_r   <= mode;
            res_sr_r <= '0;
            cnt_r    <= '0;
            c_r      <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            a_msb_r  <= a[WIDTH-1];
            b_msb_r  <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sr_r   <= a_sr_r >> 1;
          b_sr_r   <= b_sr_r >> 1;
          res_sr_r <= res_shift_s[WIDTH-1:1];
          cnt_r    <= cnt_r + CW'(1);
          c_r      <= c_nxt_s;
          // The last slice publishes straight into the outputs so that done,
          // result and cout become visible together in the DONE cycle.
          if (last_s) begin
            done_r   <= 1'b1;
            result_r <= res_shift_s;
            cout_r   <= c_nxt_s;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_r    <= ovf_s;
`endif
          end
        end
        DONE: begin
          done_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = ready_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf    = ovf_r;
`endif

endmodule
